field_bank_bcd: RTL and testbench
=================================

Name: field_bank_bcd

Overview:
- Parametrised BCD field register bank.
- Replaces the fixed 9-output decenas/unidades demultiplexer pair between the parameter-entry logic and the VGA text generator.
- Stores N_FIELDS two-digit BCD fields, written through a validated single-cycle write handshake. Fields are read through a registered random-access port driven by the text generator's field address.
- Generates the cursor blink phase internally and qualifies read data with a visibility flag.

Parameters:
- N_FIELDS, 9, number of two-digit fields (1..2**ADDR_W).
- ADDR_W, 4, width of write, read and cursor addresses.
- BLINK_DIV, 25000000, clk_i cycles per blink half-period (>=2).

Ports:
- clk_i  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- wr_en_i  in  1  write request, sampled each cycle.
- wr_addr_i  in  ADDR_W  field index to write.
- wr_dec_i  in  4  tens BCD digit.
- wr_uni_i  in  4  units BCD digit.
- wr_ack_o  out  1  one-cycle pulse: write accepted.
- wr_err_o  out  1  one-cycle pulse: write rejected.
- rd_addr_i  in  ADDR_W  field index to read.
- rd_dec_o  out  4  tens digit of read field, registered.
- rd_uni_o  out  4  units digit of read field, registered.
- rd_vis_o  out  1  read field is to be drawn this cycle, registered.
- cursor_en_i  in  1  cursor blinking enabled.
- cursor_addr_i  in  ADDR_W  field index under cursor.
- blink_o  out  1  blink phase; 1 = shown.
- fields_o  out  8*N_FIELDS  flat copy of all fields; field k at bits [8k+7:8k], tens in the upper nibble.
- commit_i  in  1  shadow commit strobe; present only with FIELD_BANK_SHADOW_EN.

Behaviour:
- Reset (reset=0, asynchronous):
  - all fields = 8'h00.
  - wr_ack_o = wr_err_o = 0.
  - rd_dec_o = rd_uni_o = 0, rd_vis_o = 1.
  - blink counter = 0, blink_o = 1.
- Release from reset is synchronous to clk_i. Any write in flight at reset assertion is discarded with no ack or err.
- Write accept/reject, evaluated on the cycle wr_en_i=1:
  - Accepted when wr_addr_i < N_FIELDS and wr_dec_i <= 9 and wr_uni_i <= 9.
  - Accepted write: field updated at that edge, wr_ack_o=1 in the following cycle.
  - Otherwise: no state change, wr_err_o=1 in the following cycle.
  - ack and err are mutually exclusive; each is 1 cycle wide.
- Back-to-back writes (wr_en_i high on consecutive cycles) are each processed independently, one per cycle, with no stall.
- Read latency is 1 cycle: rd_* reflect rd_addr_i sampled at the previous edge.
- Out-of-range rd_addr_i returns digits 0 with rd_vis_o=0.
- Read and accepted write to the same address in the same cycle: read returns the pre-write value. The new value appears on the next read.
- Blink counter:
  - Counts 0..BLINK_DIV-1, then wraps to 0 and toggles blink_o.
  - Free-running, independent of cursor_en_i.
- rd_vis_o (registered) = NOT(cursor_en_i AND rd_addr_i == cursor_addr_i) OR blink_o, with all inputs sampled at the same edge as rd_addr_i.
- fields_o is driven directly from the field (or visible) registers, so it is 0 cycles after the update edge.

Optional Feature:
- Macro FIELD_BANK_SHADOW_EN.
- Defined:
  - Accepted writes update a shadow bank only; the read port and fields_o show the visible bank.
  - commit_i=1 copies all shadow fields to the visible bank at that edge, atomically.
  - A write and a commit in the same cycle: the commit copies the pre-write shadow. The write lands in shadow only.
  - Reset clears both banks.
- Undefined: commit_i port absent; writes update the visible bank directly.

Test Plan:
- Reset, then read addr 0..8 -> every read returns 0/0 with rd_vis_o=1; fields_o=0.
- Write addr 3 with dec=2, uni=3 -> wr_ack_o pulses the next cycle; a read of addr 3 one cycle later returns 2/3; fields_o[31:24]=8'h23.
- Rejected writes, each leaving the field unchanged:
  - addr 9 (N_FIELDS=9) -> wr_err_o pulses.
  - addr 2 with uni=4'hA -> wr_err_o pulses.
  - addr 2 with dec=4'hF -> wr_err_o pulses.
- Write 4'h5/4'h9 to addr 1 with rd_addr=1 in the same cycle -> rd_* show the old value; the next cycle shows 5/9.
- BLINK_DIV=4, cursor_en=1, cursor_addr=4, rd_addr=4 -> blink_o toggles every 4 cycles; rd_vis_o follows blink_o. With rd_addr=5, rd_vis_o stays 1.
- With FIELD_BANK_SHADOW_EN: write 8'h47 to addr 0 -> reads still return 0/0. Pulse commit_i -> the next read returns 4/7. Assert reset mid-sequence -> both banks return to 0.

Source files
------------

// File: rtl/field_bank_bcd_if.sv
// Write/read handshake bundle between the parameter-entry logic (master)
// and the BCD field bank (slave).
interface field_bank_bcd_if #(
    parameter int ADDR_W = 4
);
    logic              wr_en_i;
    logic [ADDR_W-1:0] wr_addr_i;
    logic [3:0]        wr_dec_i;
    logic [3:0]        wr_uni_i;
    logic              wr_ack_o;
    logic              wr_err_o;
    logic [ADDR_W-1:0] rd_addr_i;
    logic [3:0]        rd_dec_o;
    logic [3:0]        rd_uni_o;
    logic              rd_vis_o;

    modport master (
        output wr_en_i, wr_addr_i, wr_dec_i, wr_uni_i, rd_addr_i,
        input  wr_ack_o, wr_err_o, rd_dec_o, rd_uni_o, rd_vis_o
    );

    modport slave (
        input  wr_en_i, wr_addr_i, wr_dec_i, wr_uni_i, rd_addr_i,
        output wr_ack_o, wr_err_o, rd_dec_o, rd_uni_o, rd_vis_o
    );
endinterface

// File: rtl/field_bank_bcd.sv
// Parametrised two-digit BCD field bank feeding the VGA text generator.
// Validated single-cycle writes, registered random-access read with a
// cursor-blink visibility flag, and a flat copy of every field.
// Optional macro FIELD_BANK_SHADOW_EN: writes land in a shadow bank and
// become visible only on a commit_i strobe.
module field_bank_bcd #(
    parameter int N_FIELDS  = 9,
    parameter int ADDR_W    = 4,
    parameter int BLINK_DIV = 25000000
) (
    input  logic                  clk_i,
    input  logic                  reset,
    field_bank_bcd_if.slave       bus,
    input  logic                  cursor_en_i,
    input  logic [ADDR_W-1:0]     cursor_addr_i,
`ifdef FIELD_BANK_SHADOW_EN
    input  logic                  commit_i,
`endif
    output logic                  blink_o,
    output logic [8*N_FIELDS-1:0] fields_o
);
    localparam int                CNT_W   = $clog2(BLINK_DIV);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(BLINK_DIV - 1);
    // Field count widened by one bit so 2**ADDR_W fields still compare correctly
    localparam logic [ADDR_W:0]   NF      = (ADDR_W + 1)'(N_FIELDS);

    logic [N_FIELDS-1:0][7:0] vis_q;
    logic [N_FIELDS-1:0]      wr_hit;
    logic [7:0]               rd_sel;
    logic [CNT_W-1:0]         blink_cnt;
    logic                     wr_ok;
    logic                     rd_in;
    logic                     cur_hit;

    assign wr_ok = bus.wr_en_i && ({1'b0, bus.wr_addr_i} < NF)
                   && (bus.wr_dec_i <= 4'd9) && (bus.wr_uni_i <= 4'd9);

    for (genvar k = 0; k < N_FIELDS; k++) begin : g_hit
        assign wr_hit[k] = wr_ok && (bus.wr_addr_i == ADDR_W'(k));
    end

`ifdef FIELD_BANK_SHADOW_EN
    logic [N_FIELDS-1:0][7:0] shadow_q;

    // Writes go to shadow; commit copies the pre-write shadow to visible
    always_ff @(posedge clk_i or negedge reset) begin
        if (!reset) begin
            shadow_q <= '0;
            vis_q    <= '0;
        end else begin
            for (int k = 0; k < N_FIELDS; k++)
                if (wr_hit[k]) shadow_q[k] <= {bus.wr_dec_i, bus.wr_uni_i};
            if (commit_i) vis_q <= shadow_q;
        end
    end
`else
    // Accepted writes update the visible bank directly
    always_ff @(posedge clk_i or negedge reset) begin
        if (!reset) begin
            vis_q <= '0;
        end else begin
            for (int k = 0; k < N_FIELDS; k++)
                if (wr_hit[k]) vis_q[k] <= {bus.wr_dec_i, bus.wr_uni_i};
        end
    end
`endif

    // Write outcome pulses, one cycle after the request
    always_ff @(posedge clk_i or negedge reset) begin
        if (!reset) begin
            bus.wr_ack_o <= 1'b0;
            bus.wr_err_o <= 1'b0;
        end else begin
            bus.wr_ack_o <= wr_ok;
            bus.wr_err_o <= bus.wr_en_i && !wr_ok;
        end
    end

    // Read mux; out-of-range addresses match no field and yield zero
    always_comb begin
        rd_sel = '0;
        for (int k = 0; k < N_FIELDS; k++)
            if (bus.rd_addr_i == ADDR_W'(k)) rd_sel = vis_q[k];
    end

    assign rd_in   = {1'b0, bus.rd_addr_i} < NF;
    assign cur_hit = cursor_en_i && (bus.rd_addr_i == cursor_addr_i);

    // Registered read port; the field under an enabled cursor hides in the off phase
    always_ff @(posedge clk_i or negedge reset) begin
        if (!reset) begin
            bus.rd_dec_o <= 4'd0;
            bus.rd_uni_o <= 4'd0;
            bus.rd_vis_o <= 1'b1;
        end else begin
            bus.rd_dec_o <= rd_sel[7:4];
            bus.rd_uni_o <= rd_sel[3:0];
            bus.rd_vis_o <= rd_in && (!cur_hit || blink_o);
        end
    end

    // Free-running blink divider: toggle phase every BLINK_DIV cycles
    always_ff @(posedge clk_i or negedge reset) begin
        if (!reset) begin
            blink_cnt <= '0;
            blink_o   <= 1'b1;
        end else if (blink_cnt == CNT_MAX) begin
            blink_cnt <= '0;
            blink_o   <= !blink_o;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    assign fields_o = vis_q;
endmodule

// File: tb/tb_field_bank_bcd.sv
// Self-checking bench for field_bank_bcd: directed scenarios plus a randomized
// run against a behavioural model (field arrays and an edge counter for blink).
module tb_field_bank_bcd;
    localparam int N  = 9;
    localparam int AW = 4;
    localparam int BD = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cursor_en;
    logic [AW-1:0] cursor_addr;
    logic          blink;
    logic [8*N-1:0] fields;
`ifdef FIELD_BANK_SHADOW_EN
    logic          commit;
`endif

    field_bank_bcd_if #(.ADDR_W(AW)) bus ();

    field_bank_bcd #(.N_FIELDS(N), .ADDR_W(AW), .BLINK_DIV(BD)) dut (
        .clk_i         (clk),
        .reset         (rst_n),
        .bus           (bus),
        .cursor_en_i   (cursor_en),
        .cursor_addr_i (cursor_addr),
`ifdef FIELD_BANK_SHADOW_EN
        .commit_i      (commit),
`endif
        .blink_o       (blink),
        .fields_o      (fields)
    );

    always #5 clk = ~clk;

    // Reference model
    logic [7:0] m_vis [N];
    logic [7:0] m_sh  [N];
    int         n_edges;
    int         checks = 0;
    int         passed = 0;

    function automatic bit spec_ok(int a, int d, int u);
        return (a < N) && (d <= 9) && (u <= 9);
    endfunction

    function automatic logic [8*N-1:0] exp_fields();
        logic [8*N-1:0] f;
        for (int k = 0; k < N; k++) f[8*k +: 8] = m_vis[k];
        return f;
    endfunction

    function automatic logic [7:0] exp_rd(int a);
        return (a < N) ? m_vis[a] : 8'h00;
    endfunction

    // Blink is shown during even-numbered BD-cycle periods since reset release
    function automatic bit exp_blink();
        return ((n_edges / BD) % 2) == 0;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < N; k++) begin
            m_vis[k] = 8'h00;
            m_sh[k]  = 8'h00;
        end
        n_edges = 0;
    endtask

    task automatic model_edge(bit wen, int a, int d, int u, bit cm);
`ifdef FIELD_BANK_SHADOW_EN
        if (cm) for (int k = 0; k < N; k++) m_vis[k] = m_sh[k];
        if (wen && spec_ok(a, d, u)) m_sh[a] = {d[3:0], u[3:0]};
`else
        if (wen && spec_ok(a, d, u)) m_vis[a] = {d[3:0], u[3:0]};
        if (cm) n_edges = n_edges;
`endif
    endtask

    task automatic drive(bit wen, int a, int d, int u, int ra);
        bus.wr_en_i   = wen;
        bus.wr_addr_i = AW'(a);
        bus.wr_dec_i  = 4'(d);
        bus.wr_uni_i  = 4'(u);
        bus.rd_addr_i = AW'(ra);
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) n_edges++;
        #1;
    endtask

    task automatic test_reset();
        // Land one write, then assert reset with another write pending
        drive(1, 0, 5, 5, 0);
        model_edge(1, 0, 5, 5, 0);
        tick();
        drive(1, 1, 6, 6, 0);
        #2 rst_n = 1'b0;
        model_clear();
        #1;
        checks++;
        if ({bus.wr_ack_o, bus.wr_err_o, bus.rd_dec_o, bus.rd_uni_o, bus.rd_vis_o, blink} !== 12'b00_0000_0000_11) begin
            $display("FAIL reset_outputs: got %b want 000000000011",
                     {bus.wr_ack_o, bus.wr_err_o, bus.rd_dec_o, bus.rd_uni_o, bus.rd_vis_o, blink});
        end else passed++;
        checks++;
        if (fields !== '0) $display("FAIL reset_fields: got %h want 0", fields);
        else passed++;
        tick();
        checks++;
        if (bus.wr_ack_o !== 1'b0 || bus.wr_err_o !== 1'b0)
            $display("FAIL reset_inflight: ack %b err %b want 0 0", bus.wr_ack_o, bus.wr_err_o);
        else passed++;
        drive(0, 0, 0, 0, 0);
        rst_n = 1'b1;
        for (int a = 0; a < N; a++) begin
            drive(0, 0, 0, 0, a);
            tick();
            checks++;
            if ({bus.rd_dec_o, bus.rd_uni_o, bus.rd_vis_o} !== 9'b0000_0000_1 || fields !== '0)
                $display("FAIL reset_read[%0d]: got %h%h vis %b fields %h want 00 vis 1 fields 0",
                         a, bus.rd_dec_o, bus.rd_uni_o, bus.rd_vis_o, fields);
            else passed++;
        end
    endtask

    task automatic test_write_basic();
        drive(1, 3, 2, 3, 0);
        model_edge(1, 3, 2, 3, 0);
        tick();
        checks++;
        if (bus.wr_ack_o !== 1'b1 || bus.wr_err_o !== 1'b0)
            $display("FAIL write_ack: ack %b err %b want 1 0", bus.wr_ack_o, bus.wr_err_o);
        else passed++;
        checks++;
        if (fields[31:24] !== m_vis[3]) $display("FAIL write_fields3: got %h want %h", fields[31:24], m_vis[3]);
        else passed++;
        drive(0, 0, 0, 0, 3);
        tick();
        checks++;
        if (bus.wr_ack_o !== 1'b0) $display("FAIL ack_width: got %b want 0", bus.wr_ack_o);
        else passed++;
        checks++;
        if ({bus.rd_dec_o, bus.rd_uni_o} !== exp_rd(3))
            $display("FAIL write_read3: got %h%h want %h", bus.rd_dec_o, bus.rd_uni_o, exp_rd(3));
        else passed++;
    endtask

    task automatic test_reject();
        int ca [3] = '{9, 2, 2};
        int cd [3] = '{1, 1, 15};
        int cu [3] = '{1, 10, 1};
        for (int i = 0; i < 3; i++) begin
            drive(1, ca[i], cd[i], cu[i], 2);
            model_edge(1, ca[i], cd[i], cu[i], 0);
            tick();
            checks++;
            if (bus.wr_err_o !== 1'b1 || bus.wr_ack_o !== 1'b0 || fields !== exp_fields())
                $display("FAIL reject[%0d]: err %b ack %b fields %h want 1 0 %h",
                         i, bus.wr_err_o, bus.wr_ack_o, fields, exp_fields());
            else passed++;
        end
        drive(0, 0, 0, 0, 2);
        tick();
        checks++;
        if (bus.wr_err_o !== 1'b0 || {bus.rd_dec_o, bus.rd_uni_o} !== exp_rd(2))
            $display("FAIL reject_after: err %b rd %h%h want 0 %h", bus.wr_err_o, bus.rd_dec_o, bus.rd_uni_o, exp_rd(2));
        else passed++;
    endtask

    task automatic test_same_cycle();
        logic [7:0] old_v;
        old_v = exp_rd(1);
        drive(1, 1, 5, 9, 1);
        model_edge(1, 1, 5, 9, 0);
        tick();
        checks++;
        if ({bus.rd_dec_o, bus.rd_uni_o} !== old_v)
            $display("FAIL same_cycle_old: got %h%h want %h", bus.rd_dec_o, bus.rd_uni_o, old_v);
        else passed++;
        drive(0, 0, 0, 0, 1);
        tick();
        checks++;
        if ({bus.rd_dec_o, bus.rd_uni_o} !== exp_rd(1))
            $display("FAIL same_cycle_new: got %h%h want %h", bus.rd_dec_o, bus.rd_uni_o, exp_rd(1));
        else passed++;
    endtask

    task automatic test_back_to_back();
        // Four consecutive writes, two of them invalid, no idle cycles between
        int wa [4] = '{6, 7, 12, 8};
        int wd [4] = '{8, 0, 1, 9};
        int wu [4] = '{1, 11, 1, 9};
        bit ok;
        for (int i = 0; i < 4; i++) begin
            drive(1, wa[i], wd[i], wu[i], 0);
            ok = spec_ok(wa[i], wd[i], wu[i]);
            model_edge(1, wa[i], wd[i], wu[i], 0);
            tick();
            checks++;
            if (bus.wr_ack_o !== ok || bus.wr_err_o !== !ok || fields !== exp_fields())
                $display("FAIL b2b[%0d]: ack %b err %b fields %h want %b %b %h",
                         i, bus.wr_ack_o, bus.wr_err_o, fields, ok, !ok, exp_fields());
            else passed++;
        end
        drive(0, 0, 0, 0, 0);
    endtask

    task automatic test_blink();
        bit ev;
        rst_n = 1'b0;
        model_clear();
        tick();
        rst_n = 1'b1;
        cursor_en   = 1'b1;
        cursor_addr = 4'd4;
        drive(0, 0, 0, 0, 4);
        for (int i = 0; i < 20; i++) begin
            ev = exp_blink();
            tick();
            checks++;
            if (blink !== exp_blink() || bus.rd_vis_o !== ev)
                $display("FAIL blink_cursor[%0d]: blink %b vis %b want %b %b", i, blink, bus.rd_vis_o, exp_blink(), ev);
            else passed++;
        end
        drive(0, 0, 0, 0, 5);
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (bus.rd_vis_o !== 1'b1 || blink !== exp_blink())
                $display("FAIL blink_other[%0d]: vis %b blink %b want 1 %b", i, bus.rd_vis_o, blink, exp_blink());
            else passed++;
        end
        drive(0, 0, 0, 0, 12);
        tick();
        checks++;
        if ({bus.rd_dec_o, bus.rd_uni_o, bus.rd_vis_o} !== 9'd0)
            $display("FAIL read_oor: got %h%h vis %b want 00 vis 0", bus.rd_dec_o, bus.rd_uni_o, bus.rd_vis_o);
        else passed++;
        cursor_en = 1'b0;
    endtask

    task automatic test_random();
        bit wen, cen, cm, ok, ev;
        int a, d, u, ra, ca;
        logic [7:0] er;
        for (int i = 0; i < 400; i++) begin
            wen = 1'($urandom_range(0, 1));
            a   = $urandom_range(0, 15);
            d   = ($urandom_range(0, 3) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9);
            u   = ($urandom_range(0, 3) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9);
            ra  = $urandom_range(0, 10);
            cen = 1'($urandom_range(0, 1));
            ca  = $urandom_range(0, 9);
            cm  = ($urandom_range(0, 7) == 0);
            drive(wen, a, d, u, ra);
            cursor_en   = cen;
            cursor_addr = AW'(ca);
`ifdef FIELD_BANK_SHADOW_EN
            commit = cm;
`endif
            ok = wen && spec_ok(a, d, u);
            er = exp_rd(ra);
            ev = (ra < N) && (!(cen && ra == ca) || exp_blink());
            model_edge(wen, a, d, u, cm);
            tick();
            checks++;
            if ({bus.wr_ack_o, bus.wr_err_o} !== {ok, wen && !ok})
                $display("FAIL rand_hs[%0d]: ack/err %b%b want %b%b", i, bus.wr_ack_o, bus.wr_err_o, ok, wen && !ok);
            else passed++;
            checks++;
            if ({bus.rd_dec_o, bus.rd_uni_o, bus.rd_vis_o} !== {er, ev})
                $display("FAIL rand_rd[%0d]: got %h%h vis %b want %h vis %b",
                         i, bus.rd_dec_o, bus.rd_uni_o, bus.rd_vis_o, er, ev);
            else passed++;
            checks++;
            if (fields !== exp_fields() || blink !== exp_blink())
                $display("FAIL rand_state[%0d]: fields %h blink %b want %h %b", i, fields, blink, exp_fields(), exp_blink());
            else passed++;
        end
        drive(0, 0, 0, 0, 0);
        cursor_en = 1'b0;
`ifdef FIELD_BANK_SHADOW_EN
        commit = 1'b0;
`endif
    endtask

`ifdef FIELD_BANK_SHADOW_EN
    task automatic test_shadow();
        rst_n = 1'b0;
        model_clear();
        tick();
        rst_n = 1'b1;
        drive(1, 0, 4, 7, 0);
        tick();
        drive(0, 0, 0, 0, 0);
        tick();
        checks++;
        if ({bus.rd_dec_o, bus.rd_uni_o} !== 8'h00 || fields !== '0)
            $display("FAIL shadow_hidden: got %h%h fields %h want 00 0", bus.rd_dec_o, bus.rd_uni_o, fields);
        else passed++;
        commit = 1'b1;
        tick();
        commit = 1'b0;
        tick();
        checks++;
        if ({bus.rd_dec_o, bus.rd_uni_o} !== 8'h47)
            $display("FAIL shadow_commit: got %h%h want 47", bus.rd_dec_o, bus.rd_uni_o);
        else passed++;
        drive(1, 2, 3, 3, 0);
        tick();
        drive(0, 0, 0, 0, 0);
        rst_n = 1'b0;
        model_clear();
        tick();
        rst_n = 1'b1;
        commit = 1'b1;
        tick();
        commit = 1'b0;
        checks++;
        if (fields !== '0) $display("FAIL shadow_reset: fields %h want 0", fields);
        else passed++;
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        cursor_en = 1'b0;
        cursor_addr = '0;
`ifdef FIELD_BANK_SHADOW_EN
        commit = 1'b0;
`endif
        drive(0, 0, 0, 0, 0);
        model_clear();
        tick();
        tick();
        rst_n = 1'b1;
        test_reset();
        test_write_basic();
        test_reject();
        test_same_cycle();
        test_back_to_back();
        test_blink();
        test_random();
`ifdef FIELD_BANK_SHADOW_EN
        test_shadow();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
